// File: rtl/usb_rx_packer.sv
// usb_rx_packer: packs bridge bytes/words into 16-bit words and buffers them in a FWFT FIFO.
// Latency: a word pushed at edge N is at the FIFO head (OUT_VALID=1) in cycle N+1.
// Backpressure: IN_READY=0 at count=DEPTH (drops set OVERFLOW); ALMOST_FULL at DEPTH-AF_MARGIN.
// Optional statistics counters are built when USB_RX_STATS_EN is defined.

// sync_fifo: generic single-clock first-word-fall-through FIFO with occupancy count.
// Latency: write at edge N appears at rd_dat with rd_vld=1 in cycle N+1; no pass-through.
// Backpressure: writes are ignored while full (count=DEPTH), even if a read happens that cycle.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign full   = (count == FULL_LVL);
  assign rd_vld = (count != '0);
  assign wr_en  = wr_vld & ~full;
  assign rd_en  = rd_vld & rd_rdy;
  assign rd_dat = mem[rptr];

  // Storage array: no reset needed, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// usb_rx_packer: byte packer + FIFO between the USB FIFO bridge and the application stream.
// Latency: full words 1 cycle to OUT_VALID; held bytes wait for their partner byte or a flush.
// Backpressure: IN_READY/ALMOST_FULL from FIFO count only; words arriving at IN_READY=0 are dropped.
module usb_rx_packer #(
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic [15:0] IN_DATA,
  input  logic [1:0]  IN_BE,
  output logic        IN_READY,
  output logic        ALMOST_FULL,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  output logic [15:0] OUT_DATA,
  output logic [1:0]  OUT_BE,
  input  logic        OUT_READY,
  output logic        OVERFLOW,
  output logic [31:0] WORD_COUNT,
  output logic [15:0] DROP_COUNT
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_MARGIN);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pk_state_t;

  pk_state_t   state;
  pk_state_t   state_nxt;
  logic [7:0]  hold;
  logic [7:0]  hold_nxt;
  logic        flush_pending;
  logic        flush_nxt;
  logic        overflow_q;

  logic        accept;
  logic        drop;
  logic [7:0]  sel_byte;
  logic        push_vld;
  logic [15:0] push_dat;
  logic [1:0]  push_be;

  logic [AW:0] fifo_cnt;
  logic [17:0] fifo_head;

  // Flow-control outputs depend on the FIFO count only, never on inputs.
  assign IN_READY    = (fifo_cnt < FULL_LVL);
  assign ALMOST_FULL = (fifo_cnt >= AF_LVL);
  assign accept      = IN_VALID & IN_READY;
  assign drop        = IN_VALID & ~IN_READY;
  assign sel_byte    = IN_BE[0] ? IN_DATA[7:0] : IN_DATA[15:8];
  assign OVERFLOW    = overflow_q;
  assign OUT_BE      = fifo_head[17:16];
  assign OUT_DATA    = fifo_head[15:0];

  // Packer state register plus pending-flush and sticky overflow flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= ST_EMPTY;
      hold          <= 8'h00;
      flush_pending <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold          <= hold_nxt;
      flush_pending <= flush_nxt;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Next-state and FIFO push decode; accepted input takes priority over a pending flush.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    flush_nxt = flush_pending | FLUSH;
    push_vld  = 1'b0;
    push_dat  = 16'h0000;
    push_be   = 2'b00;
    if (accept) begin
      case (IN_BE)
        2'b11: begin
          push_vld = 1'b1;
          push_be  = 2'b11;
          if (state == ST_EMPTY) begin
            push_dat = IN_DATA;
          end else begin
            // Held byte is earlier: it goes low, the new low byte completes the word.
            push_dat = {IN_DATA[7:0], hold};
            hold_nxt = IN_DATA[15:8];
          end
        end
        2'b01, 2'b10: begin
          if (state == ST_EMPTY) begin
            hold_nxt  = sel_byte;
            state_nxt = ST_HALF;
          end else begin
            push_vld  = 1'b1;
            push_be   = 2'b11;
            push_dat  = {sel_byte, hold};
            state_nxt = ST_EMPTY;
          end
        end
        default: begin
          // No byte enables: nothing to pack.
        end
      endcase
    end else if (flush_pending && IN_READY) begin
      // A FLUSH arriving this very cycle is a fresh request and stays pending.
      flush_nxt = FLUSH;
      if (state == ST_HALF) begin
        push_vld  = 1'b1;
        push_be   = 2'b01;
        push_dat  = {8'h00, hold};
        state_nxt = ST_EMPTY;
      end
    end
  end

  sync_fifo #(
    .WIDTH (18),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .wr_vld (push_vld),
    .wr_dat ({push_be, push_dat}),
    .rd_rdy (OUT_READY),
    .rd_vld (OUT_VALID),
    .rd_dat (fifo_head),
    .count  (fifo_cnt)
  );

`ifdef USB_RX_STATS_EN
  logic [31:0] word_cnt;
  logic [15:0] drop_cnt;

  // Push counter wraps; drop counter saturates so a long stall stays visible.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_cnt <= 32'd0;
      drop_cnt <= 16'd0;
    end else begin
      if (push_vld) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign WORD_COUNT = word_cnt;
  assign DROP_COUNT = drop_cnt;
`else
  assign WORD_COUNT = 32'd0;
  assign DROP_COUNT = 16'd0;
`endif
endmodule
